// File: rtl/filter_pkg.sv
// Shared types and width helpers for the moving-average filter.
// Holds the FSM state encoding and the window-depth legality check.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } filterState_e;

    localparam int MinDepth = 2;
    localparam int MaxDepth = 256;

    function automatic bit depthIsLegal(input int depth);
        return (depth >= MinDepth) && (depth <= MaxDepth)
            && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptrWidth(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int sumWidth(input int dataWidth, input int depth);
        return dataWidth + ptrWidth(depth);
    endfunction

endpackage

// File: rtl/moving_average_history.sv
// Per-channel circular sample history, one read and one write port.
// Reads are combinational, so a same-cycle write still returns the old entry.
module moving_average_history #(
    parameter int NumChannels = 3,
    parameter int DataWidth   = 10,
    parameter int Depth       = 64,
    parameter int ChanWidth   = 2,
    parameter int PtrWidth    = 6
) (
    input  logic                 Clock,
    input  logic                 WrEn,
    input  logic [ChanWidth-1:0] WrChan,
    input  logic [PtrWidth-1:0]  WrPtr,
    input  logic [DataWidth-1:0] WrData,
    input  logic [ChanWidth-1:0] RdChan,
    input  logic [PtrWidth-1:0]  RdPtr,
    output logic [DataWidth-1:0] RdData
);

    logic [DataWidth-1:0] mem [NumChannels][Depth];

    always_ff @(posedge Clock) begin
        if (WrEn) begin
            mem[WrChan][WrPtr] <= WrData;
        end
    end

    assign RdData = mem[RdChan][RdPtr];

endmodule

// File: rtl/moving_average_filter.sv
// Multi-channel boxcar filter: running sum per channel over a circular
// history, channels time-multiplexed through one adder.
module moving_average_filter
    import filter_pkg::*;
#(
    parameter int NumChannels = 3,
    parameter int DataWidth   = 10,
    parameter int Depth       = 64,
    parameter bit IsSigned    = 1'b1
) (
    input  logic                             Clock,
    input  logic                             Reset_n,
    input  logic                             InValid,
    output logic                             InReady,
    input  logic [NumChannels*DataWidth-1:0] InData,
    input  logic                             Flush,
    input  logic                             Bypass,
    output logic                             OutValid,
    output logic [NumChannels*DataWidth-1:0] OutData,
    output logic                             Primed,
    output logic                             Overrun
);

    localparam int PtrWidth  = ptrWidth(Depth);
    localparam int ChanWidth = idxWidth(NumChannels);
    localparam int SumWidth  = sumWidth(DataWidth, Depth);
    localparam int FillWidth = PtrWidth + 1;
    localparam int BusWidth  = NumChannels * DataWidth;

    if (!depthIsLegal(Depth)) begin : gBadDepth
        $error("moving_average_filter: Depth must be a power of two in 2..256");
    end

    filterState_e stateQ, stateD;

    logic [ChanWidth-1:0] chanQ;
    logic [PtrWidth-1:0]  ptrQ;
    logic [FillWidth-1:0] fillQ;
    logic [BusWidth-1:0]  inDataQ;
    logic [BusWidth-1:0]  outDataQ;
    logic [BusWidth-1:0]  emitData;
    logic                 bypassQ;
    logic                 outValidQ;
    logic                 overrunQ;

    logic [SumWidth-1:0]  sumQ [NumChannels];
    logic [DataWidth-1:0] inSample [NumChannels];

    logic                 accept;
    logic                 windowFull;
    logic                 lastChan;
    logic                 histWrEn;
    logic [DataWidth-1:0] newSample;
    logic [DataWidth-1:0] oldSample;
    logic [DataWidth-1:0] histRd;
    logic [SumWidth-1:0]  newExt;
    logic [SumWidth-1:0]  oldExt;
    logic [SumWidth-1:0]  sumNext;

    for (genvar c = 0; c < NumChannels; c++) begin : gSplit
        assign inSample[c] = inDataQ[c*DataWidth +: DataWidth];
    end

    assign InReady    = (stateQ == IDLE);
    assign accept     = InValid && InReady && !Flush;
    assign windowFull = (fillQ == FillWidth'(Depth));
    assign lastChan   = (chanQ == ChanWidth'(NumChannels - 1));
    assign histWrEn   = (stateQ == ACCUM) && !Flush;
    assign newSample  = inSample[chanQ];

    assign OutValid = outValidQ;
    assign OutData  = outDataQ;
    assign Primed   = windowFull;
    assign Overrun  = overrunQ;

    moving_average_history #(
        .NumChannels(NumChannels),
        .DataWidth  (DataWidth),
        .Depth      (Depth),
        .ChanWidth  (ChanWidth),
        .PtrWidth   (PtrWidth)
    ) uHistory (
        .Clock (Clock),
        .WrEn  (histWrEn),
        .WrChan(chanQ),
        .WrPtr (ptrQ),
        .WrData(newSample),
        .RdChan(chanQ),
        .RdPtr (ptrQ),
        .RdData(histRd)
    );

    // Slots not yet written since reset/flush count as zero.
    always_comb begin
        oldSample = windowFull ? histRd : '0;
        if (IsSigned) begin
            newExt = {{PtrWidth{newSample[DataWidth-1]}}, newSample};
            oldExt = {{PtrWidth{oldSample[DataWidth-1]}}, oldSample};
        end else begin
            newExt = {{PtrWidth{1'b0}}, newSample};
            oldExt = {{PtrWidth{1'b0}}, oldSample};
        end
        sumNext = sumQ[chanQ] + newExt - oldExt;
    end

    // Dropping the low bits of a two's-complement sum floors toward -inf.
    always_comb begin
        emitData = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (bypassQ) begin
                emitData[c*DataWidth +: DataWidth] = inSample[c];
            end else begin
                emitData[c*DataWidth +: DataWidth] = sumQ[c][SumWidth-1:PtrWidth];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (accept) begin
                    stateD = ACCUM;
                end
            end
            ACCUM: begin
                if (lastChan) begin
                    stateD = EMIT;
                end
            end
            EMIT: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
        if (Flush) begin
            stateD = IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            chanQ   <= '0;
            inDataQ <= '0;
            bypassQ <= 1'b0;
        end else if (Flush) begin
            chanQ <= '0;
        end else if (accept) begin
            chanQ   <= '0;
            inDataQ <= InData;
            bypassQ <= Bypass;
        end else if (stateQ == ACCUM) begin
            chanQ <= lastChan ? '0 : chanQ + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < NumChannels; c++) begin
                sumQ[c] <= '0;
            end
        end else if (Flush) begin
            for (int c = 0; c < NumChannels; c++) begin
                sumQ[c] <= '0;
            end
        end else if (stateQ == ACCUM) begin
            for (int c = 0; c < NumChannels; c++) begin
                if (chanQ == ChanWidth'(c)) begin
                    sumQ[c] <= sumNext;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptrQ      <= '0;
            fillQ     <= '0;
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            overrunQ  <= 1'b0;
        end else if (Flush) begin
            ptrQ      <= '0;
            fillQ     <= '0;
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            overrunQ  <= 1'b0;
        end else begin
            outValidQ <= (stateQ == EMIT);
            if (InValid && !InReady) begin
                overrunQ <= 1'b1;
            end
            if (stateQ == EMIT) begin
                ptrQ     <= ptrQ + 1'b1;
                outDataQ <= emitData;
                if (!windowFull) begin
                    fillQ <= fillQ + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench for moving_average_filter with a 3-channel,
// 10-bit, depth-4 signed configuration.
module tb_moving_average_filter;

    localparam int NCh = 3;
    localparam int DW  = 10;
    localparam int Dep = 4;

    logic            Clock = 1'b0;
    logic            Reset_n;
    logic            InValid = 1'b0;
    logic            InReady;
    logic [NCh*DW-1:0] InData = '0;
    logic            Flush = 1'b0;
    logic            Bypass = 1'b0;
    logic            OutValid;
    logic [NCh*DW-1:0] OutData;
    logic            Primed;
    logic            Overrun;

    moving_average_filter #(
        .NumChannels(NCh),
        .DataWidth  (DW),
        .Depth      (Dep),
        .IsSigned   (1'b1)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .InValid (InValid),
        .InReady (InReady),
        .InData  (InData),
        .Flush   (Flush),
        .Bypass  (Bypass),
        .OutValid(OutValid),
        .OutData (OutData),
        .Primed  (Primed),
        .Overrun (Overrun)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0] e0, e1, e2;
        logic       prim;
        int         due;
        string      tag;
    } exp_t;

    typedef struct {
        logic [9:0] d0, d1, d2;
        logic [9:0] e0, e1, e2;
        logic       prim;
    } vec_t;

    exp_t sbq[$];
    exp_t monExp;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    always @(negedge Clock) begin
        if (OutValid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious OutValid at cycle %0d: got %0h", cyc, OutData);
            end else begin
                monExp = sbq.pop_front();
                check({monExp.tag, "/ch0"}, OutData[9:0], monExp.e0);
                check({monExp.tag, "/ch1"}, OutData[19:10], monExp.e1);
                check({monExp.tag, "/ch2"}, OutData[29:20], monExp.e2);
                check({monExp.tag, "/primed"}, Primed, monExp.prim);
                check({monExp.tag, "/latency"}, cyc, monExp.due);
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!InReady && n < 50) begin
            @(negedge Clock);
            n++;
        end
        if (!InReady) check("InReady timeout", InReady, 1);
    endtask

    task automatic drive(input logic [9:0] d0, d1, d2, input logic byp,
                         input logic expectOut,
                         input logic [9:0] e0, e1, e2, input logic prim,
                         input string tag, input int hold);
        exp_t x;
        waitReady();
        InData  = {d2, d1, d0};
        Bypass  = byp;
        InValid = 1'b1;
        if (expectOut) begin
            x.e0 = e0; x.e1 = e1; x.e2 = e2;
            x.prim = prim; x.due = cyc + 5; x.tag = tag;
            sbq.push_back(x);
        end
        repeat (hold) @(negedge Clock);
        InValid = 1'b0;
        Bypass  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain timeout: %0d outputs missing, want 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic checkIdleState(input string tag);
        check({tag, "/InReady"}, InReady, 1);
        check({tag, "/OutValid"}, OutValid, 0);
        check({tag, "/OutData"}, OutData, 0);
        check({tag, "/Primed"}, Primed, 0);
        check({tag, "/Overrun"}, Overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{10'd100, 10'h3F8, 10'h1FF, 10'd25,  10'h3FE, 10'd127, 1'b0};
        tbl[1] = '{10'd100, 10'h3F8, 10'h1FF, 10'd50,  10'h3FC, 10'd255, 1'b0};
        tbl[2] = '{10'd100, 10'h3F8, 10'h1FF, 10'd75,  10'h3FA, 10'd383, 1'b0};
        tbl[3] = '{10'd100, 10'h3F8, 10'h1FF, 10'd100, 10'h3F8, 10'd511, 1'b1};
        tbl[4] = '{10'd200, 10'h3F8, 10'h200, 10'd125, 10'h3F8, 10'h0FF, 1'b1};
        tbl[5] = '{10'd200, 10'h3F8, 10'h200, 10'd150, 10'h3F8, 10'h3FF, 1'b1};
        tbl[6] = '{10'd200, 10'h3F8, 10'h200, 10'd175, 10'h3F8, 10'h2FF, 1'b1};
        tbl[7] = '{10'd200, 10'h3F8, 10'h200, 10'd200, 10'h3F8, 10'h200, 1'b1};

        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        checkIdleState("reset");
        Reset_n = 1'b1;
        @(negedge Clock);

        // step, wrap and signed extremes
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].d0, tbl[i].d1, tbl[i].d2, 1'b0, 1'b1,
                  tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].prim,
                  $sformatf("vec%0d", i), 1);
        end
        drain();

        // asynchronous reset in the middle of ACCUM
        drive(10'd1, 10'd1, 10'd1, 1'b0, 1'b0, '0, '0, '0, 1'b0, "", 1);
        #2 Reset_n = 1'b0;
        #1 checkIdleState("asyncReset");
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        // signed floor and ageing-out of the negative sample
        drive(10'd0, 10'h3FD, 10'd0, 1'b0, 1'b1, 10'd0, 10'h3FF, 10'd0, 1'b0, "neg3", 1);
        drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b1, 10'd0, 10'h3FF, 10'd0, 1'b0, "zero1", 1);
        drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b1, 10'd0, 10'h3FF, 10'd0, 1'b0, "zero2", 1);
        drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b1, 10'd0, 10'h3FF, 10'd0, 1'b1, "zero3", 1);
        drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b1, 10'd0, 10'd0, 10'd0, 1'b1, "zero4", 1);
        drain();

        // overrun, then bypass still feeding the history
        check("overrunBefore", Overrun, 0);
        drive(10'd40, 10'd0, 10'd0, 1'b0, 1'b1, 10'd10, 10'd0, 10'd0, 1'b1, "ovr", 2);
        check("overrunSet", Overrun, 1);
        drive(10'd5, 10'h3F0, 10'd7, 1'b1, 1'b1, 10'd5, 10'h3F0, 10'd7, 1'b1, "bypass", 1);
        drive(10'd0, 10'd0, 10'd0, 1'b0, 1'b1, 10'd11, 10'h3FC, 10'd1, 1'b1, "postBypass", 1);
        drain();
        check("overrunSticky", Overrun, 1);

        // flush mid-ACCUM, then flush colliding with InValid
        drive(10'd9, 10'd9, 10'd9, 1'b0, 1'b0, '0, '0, '0, 1'b0, "", 1);
        Flush = 1'b1;
        @(negedge Clock);
        Flush = 1'b0;
        repeat (8) @(negedge Clock);
        checkIdleState("flush");
        InData  = {10'd0, 10'd0, 10'd100};
        InValid = 1'b1;
        Flush   = 1'b1;
        @(negedge Clock);
        InValid = 1'b0;
        Flush   = 1'b0;
        repeat (6) @(negedge Clock);
        check("flushInValidOverrun", Overrun, 0);
        drive(10'd100, 10'd0, 10'd0, 1'b0, 1'b1, 10'd25, 10'd0, 10'd0, 1'b0, "postFlush", 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
